dac_serial_writer: RTL

Serial transmit stage between the sound sample generator and the external 8-bit audio DAC. Accepts one 8-bit sample per `write` pulse, prepends a fixed control byte, and shifts the 16-bit frame MSB-first over a three-wire SYNC/SCLK/DIN link. `busy` is reported back upstream for flow control. Sits directly downstream of the sound controller, at the board pins.

---
 rtl/dac_pkg.sv | 27 ++
 rtl/dac_sclk_gen.sv | 56 +++++
 rtl/dac_serial_writer.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/dac_pkg.sv
// ----------------------------------------------------------------------------
// dac_pkg
// Shared definitions for the DAC serial transmit stage:
//   - dac_state_t           : FSM state encoding (IDLE, SHIFT, HOLD)
//   - DAC_FRAME_BITS        : serial frame length (control byte + sample)
//   - DAC_HOLD_HALF_PERIODS : number of divider half-periods SYNC stays high
//                             between frames
//   - dac_build_frame()     : assembles the 16-bit frame from its two bytes
// ----------------------------------------------------------------------------
package dac_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd2
    } dac_state_t;

    localparam int DAC_FRAME_BITS        = 16;
    localparam int DAC_HOLD_HALF_PERIODS = 2;

    // Control byte occupies the upper half so it goes out first (MSB-first).
    function automatic logic [15:0] dac_build_frame(input logic [7:0] ctrl,
                                                    input logic [7:0] sample);
        return {ctrl, sample};
    endfunction

endpackage

// File: rtl/dac_sclk_gen.sv
// ----------------------------------------------------------------------------
// dac_sclk_gen
// Half-period counter for the DAC serial clock. Counts 0..CLK_DIV-1 and raises
// phase_tick for one cycle while the counter sits on its last value, so the
// consumer acts on the edge that closes each half-period. A restart pulse
// puts the counter back to 0 on the same edge, aligning the first
// half-period with the start of a frame.
//
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous active-low reset
//   restart    in   restart the half-period from count 0 on this edge
//   phase_tick out  registered, high during the last cycle of a half-period
// ----------------------------------------------------------------------------
module dac_sclk_gen
    import dac_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic phase_tick
);

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    logic [7:0] cnt_r;
    logic [7:0] cnt_nxt_s;

    // Next divider count: wraps at DIV_LAST, forced to 0 on restart.
    always_comb begin
        cnt_nxt_s = 8'd0;
        if (restart) begin
            cnt_nxt_s = 8'd0;
        end else if (cnt_r == DIV_LAST) begin
            cnt_nxt_s = 8'd0;
        end else begin
            cnt_nxt_s = cnt_r + 8'd1;
        end
    end

    // Divider register; the tick is decoded from the next count so it is
    // registered yet coincides with the counter's last value (CLK_DIV=1
    // therefore ticks every cycle, including the cycle right after restart).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r      <= 8'd0;
            phase_tick <= (DIV_LAST == 8'd0);
        end else begin
            cnt_r      <= cnt_nxt_s;
            phase_tick <= (cnt_nxt_s == DIV_LAST);
        end
    end

endmodule

// File: rtl/dac_serial_writer.sv
// ----------------------------------------------------------------------------
// dac_serial_writer
// Serial transmit stage to an external 8-bit audio DAC. Each accepted write
// sends the frame {CTRL_WORD, data} MSB-first over SYNC/SCLK/DIN, followed by
// a SYNC-high gap of two divider half-periods. busy covers frame plus gap.
//
// Parameters:
//   CLK_DIV   half-period of dac_clk in clk cycles (1..255)
//   CTRL_WORD control byte sent as frame bits [15:8]
//
// Ports:
//   clk      in   system clock
//   rst      in   asynchronous active-low reset
//   data     in   [7:0] sample, captured on an accepted write
//   write    in   write request
//   busy     out  frame or hold gap in progress
//   dac_clk  out  serial clock, idles low, DAC samples on its rising edge
//   dac_sync out  frame sync, active low, idles high
//   dac_data out  serial data, changes only at the start of a low phase
//
// Build option:
//   DAC_PENDING_BUFFER_EN  when defined, a write during busy is kept in a
//                          one-entry pending register (last write wins) and
//                          sent straight after the hold gap; a write landing
//                          on the gap-expiry edge starts a frame itself and
//                          discards the pending entry. When undefined, writes
//                          during busy are dropped.
// ----------------------------------------------------------------------------
module dac_serial_writer
    import dac_pkg::*;
#(
    parameter int unsigned CLK_DIV   = 4,
    parameter logic [7:0]  CTRL_WORD = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       write,
    output logic       busy,
    output logic       dac_clk,
    output logic       dac_sync,
    output logic       dac_data
);

    dac_state_t  state_r;
    logic [3:0]  bit_cnt_r;     // bit index in SHIFT, half-periods left in HOLD
    logic [15:0] shift_r;       // remaining frame bits, next bit at [15]
    logic        phase_tick_s;
    logic        start_s;       // a frame starts on this edge
    logic [7:0]  start_data_s;  // sample used by that frame
    logic [15:0] frame_s;

`ifdef DAC_PENDING_BUFFER_EN
    logic        pend_valid_r;
    logic [7:0]  pend_data_r;
    logic        hold_done_s;
`endif

    dac_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .clk        (clk),
        .rst        (rst),
        .restart    (start_s),
        .phase_tick (phase_tick_s)
    );

    // Frame-start decision and the sample it carries.
    always_comb begin
        start_s      = 1'b0;
        start_data_s = data;
`ifdef DAC_PENDING_BUFFER_EN
        hold_done_s  = (state_r == ST_HOLD) && phase_tick_s && (bit_cnt_r == 4'd0);
`endif
        case (state_r)
            ST_IDLE: begin
                start_s = write;
            end
            ST_HOLD: begin
`ifdef DAC_PENDING_BUFFER_EN
                // A fresh write beats the pending entry at gap expiry.
                if (hold_done_s && write) begin
                    start_s      = 1'b1;
                    start_data_s = data;
                end else if (hold_done_s && pend_valid_r) begin
                    start_s      = 1'b1;
                    start_data_s = pend_data_r;
                end else begin
                    start_s = 1'b0;
                end
`else
                start_s = 1'b0;
`endif
            end
            default: begin
                start_s = 1'b0;
            end
        endcase
        frame_s = dac_build_frame(CTRL_WORD, start_data_s);
    end

    // Transmit FSM with registered serial outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= ST_IDLE;
            bit_cnt_r <= 4'd0;
            shift_r   <= 16'd0;
            busy      <= 1'b0;
            dac_sync  <= 1'b1;
            dac_clk   <= 1'b0;
            dac_data  <= 1'b0;
        end else if (start_s) begin
            // First bit goes out immediately; the register keeps the rest.
            state_r   <= ST_SHIFT;
            bit_cnt_r <= 4'(DAC_FRAME_BITS - 1);
            shift_r   <= {frame_s[14:0], 1'b0};
            busy      <= 1'b1;
            dac_sync  <= 1'b0;
            dac_clk   <= 1'b0;
            dac_data  <= frame_s[15];
        end else begin
            case (state_r)
                ST_IDLE: begin
                    busy     <= 1'b0;
                    dac_sync <= 1'b1;
                    dac_clk  <= 1'b0;
                    dac_data <= 1'b0;
                end
                ST_SHIFT: begin
                    if (phase_tick_s) begin
                        if (!dac_clk) begin
                            dac_clk <= 1'b1;
                        end else if (bit_cnt_r == 4'd0) begin
                            state_r   <= ST_HOLD;
                            bit_cnt_r <= 4'(DAC_HOLD_HALF_PERIODS - 1);
                            dac_clk   <= 1'b0;
                            dac_sync  <= 1'b1;
                            dac_data  <= 1'b0;
                        end else begin
                            dac_clk   <= 1'b0;
                            dac_data  <= shift_r[15];
                            shift_r   <= {shift_r[14:0], 1'b0};
                            bit_cnt_r <= bit_cnt_r - 4'd1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (phase_tick_s) begin
                        if (bit_cnt_r == 4'd0) begin
                            state_r <= ST_IDLE;
                            busy    <= 1'b0;
                        end else begin
                            bit_cnt_r <= bit_cnt_r - 4'd1;
                        end
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    bit_cnt_r <= 4'd0;
                    busy      <= 1'b0;
                    dac_sync  <= 1'b1;
                    dac_clk   <= 1'b0;
                    dac_data  <= 1'b0;
                end
            endcase
        end
    end

`ifdef DAC_PENDING_BUFFER_EN
    // One-entry pending sample; cleared whenever a frame starts out of HOLD,
    // whether it was used or superseded by a fresh write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_valid_r <= 1'b0;
            pend_data_r  <= 8'h00;
        end else if (start_s && (state_r == ST_HOLD)) begin
            pend_valid_r <= 1'b0;
        end else if (write && busy) begin
            pend_valid_r <= 1'b1;
            pend_data_r  <= data;
        end
    end
`endif

endmodule
